// File: rtl/mission_sequencer.sv
// mission_sequencer
// Top-level run controller for the line-following car. Sequences the
// tracking/u-turn block through LAPS track segments:
//   TRACK -> PAUSE1 -> UTURN -> PAUSE2 -> TRACK ... -> DONE
// A single phase counter serves both as the pause timer and as the
// per-phase watchdog. When the watchdog expires, the sequencer enters a
// sticky FAULT state.
//
// Ports:
//   rst            in   async active-low reset
//   clk            in   clock
//   start          in   run request (acted on only in IDLE or DONE)
//   abort          in   emergency stop; overrides every other event
//   end_of_track   in   tracking block reports that all IR sensors see black
//   uturn_finished in   tracking block reports a completed u-turn
//   en_tracking    out  enable line tracking
//   en_uturn       out  enable u-turn
//   lap_count[3:0] out  completed track segments in the current run
//   busy           out  run in progress (TRACK..PAUSE2)
//   done           out  run completed
//   fault          out  watchdog expired (sticky until abort or rst)
//
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state register.
module mission_sequencer #(
  parameter int LAPS           = 2,
  parameter int PAUSE_CYCLES   = 6,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 8
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       start,
  input  logic       abort,
  input  logic       end_of_track,
  input  logic       uturn_finished,
  output logic       en_tracking,
  output logic       en_uturn,
  output logic [3:0] lap_count,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRACK,
    S_PAUSE1,
    S_UTURN,
    S_PAUSE2,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] PAUSE_LAST   = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAPS_L       = 4'(LAPS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lap_q, lap_d;
  logic             en_tracking_q, en_tracking_d;
  logic             en_uturn_q, en_uturn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  // Next-state logic. Same-cycle priorities: abort beats everything;
  // a status input beats the watchdog in the same phase.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    lap_d   = lap_q;

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      lap_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_TRACK;
            cnt_d   = '0;
            lap_d   = '0;
          end
        end
        S_TRACK: begin
          if (end_of_track) begin
            state_d = S_PAUSE1;
            cnt_d   = '0;
            lap_d   = lap_q + 4'd1;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PAUSE1: begin
          if (cnt_q == PAUSE_LAST) begin
            state_d = (lap_q == LAPS_L) ? S_DONE : S_UTURN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_UTURN: begin
          if (uturn_finished) begin
            state_d = S_PAUSE2;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PAUSE2: begin
          // Wait out the pause and for the tracking block to release
          // uturn_finished. The counter saturates rather than wrapping
          // while uturn_finished is held.
          if (cnt_q >= PAUSE_LAST && !uturn_finished) begin
            state_d = S_TRACK;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_TRACK;
            cnt_d   = '0;
            lap_d   = '0;
          end
        end
        S_FAULT: ;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          lap_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    en_tracking_d = (state_d == S_TRACK);
    en_uturn_d    = (state_d == S_UTURN);
    busy_d        = (state_d == S_TRACK)  || (state_d == S_PAUSE1) ||
                    (state_d == S_UTURN)  || (state_d == S_PAUSE2);
    done_d        = (state_d == S_DONE);
    fault_d       = (state_d == S_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lap_q         <= '0;
      en_tracking_q <= 1'b0;
      en_uturn_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lap_q         <= lap_d;
      en_tracking_q <= en_tracking_d;
      en_uturn_q    <= en_uturn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
    end
  end

  assign en_tracking = en_tracking_q;
  assign en_uturn    = en_uturn_q;
  assign lap_count   = lap_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;

endmodule

// File: doc/mission_sequencer.md
Name: mission_sequencer

Overview:
Top-level run controller for the line-following car. It sequences the tracking/u-turn block through a fixed number of track segments: track, pause, u-turn, pause, track again, and so on. It drives the tracking and u-turn enable inputs and consumes the end_of_track and uturn_finished status outputs. It adds a per-phase watchdog and a sticky fault, and reports progress to the display/LED logic.

Parameters:
LAPS, 2, number of track segments per run (legal 1..15)
PAUSE_CYCLES, 6, settle cycles between phases (hardware value 15000000 = 0.3 s)
TIMEOUT_CYCLES, 40, maximum cycles allowed in TRACK, UTURN or PAUSE2 (hardware value 1500000000 = 30 s)
CNT_W, 8, width of the shared phase counter (hardware value 31); must hold TIMEOUT_CYCLES

Ports:
rst  in  1  reset, asynchronous, active-low
clk  in  1  clock
start  in  1  run request; level sampled each cycle, acted on only in IDLE or DONE
abort  in  1  emergency stop; highest priority
end_of_track  in  1  from tracking block; all four IR sensors black
uturn_finished  in  1  from tracking block; high until en_uturn is dropped
en_tracking  out  1  enable tracking
en_uturn  out  1  enable u-turn
lap_count  out  4  completed track segments in the current run
busy  out  1  run in progress (TRACK..PAUSE2)
done  out  1  run completed
fault  out  1  watchdog expired

Behaviour:
- All outputs are registered and decoded from the next state, so they change on the same edge as the state. Latency from an input to an output is 1 cycle.
- Reset values: state IDLE; all outputs 0; counter 0.
- States are IDLE, TRACK, PAUSE1, UTURN, PAUSE2, DONE, FAULT. Encoding is free.
- Output decode by state:
  - TRACK: en_tracking=1.
  - UTURN: en_uturn=1.
  - TRACK, PAUSE1, UTURN, PAUSE2: busy=1.
  - DONE: done=1.
  - FAULT: fault=1.
  - en_tracking and en_uturn are never high together.
- abort=1 in any state forces IDLE on the next edge, clears lap_count and the counter, and drops all outputs. abort wins over start and every other event in the same cycle.
- IDLE: start=1 -> TRACK; lap_count=0; counter=0.
- TRACK:
  - end_of_track=1 -> PAUSE1; lap_count+1; counter=0.
  - Else, counter==TIMEOUT_CYCLES-1 -> FAULT.
  - Else counter+1.
  - If end_of_track and timeout occur in the same cycle, end_of_track wins.
- PAUSE1: counter counts to PAUSE_CYCLES-1, then:
  - lap_count==LAPS -> DONE;
  - otherwise -> UTURN, counter=0.
  - Dropping en_tracking lets the tracking block return to STOP and clear end_of_track.
- UTURN:
  - uturn_finished=1 -> PAUSE2; counter=0.
  - Else timeout -> FAULT.
  - uturn_finished wins a same-cycle tie.
- PAUSE2: exit to TRACK (counter=0) only when counter >= PAUSE_CYCLES-1 and uturn_finished==0. The counter saturates; it does not wrap. If uturn_finished is still 1 when counter==TIMEOUT_CYCLES-1 -> FAULT.
- DONE: holds lap_count. start=1 -> TRACK with lap_count cleared to 0 (restart).
- FAULT: sticky. Exit only by abort or rst. start is ignored. lap_count is frozen.
- start asserted while busy is ignored; no queuing.
- The counter never wraps. lap_count never exceeds LAPS.
- rst asserted mid-run returns everything to reset values immediately (asynchronous).

Test Plan:
- Nominal, LAPS=2: start pulse; end_of_track at cycle 10.
  - en_tracking 1 from cycle 1 to 10; PAUSE1 6 cycles; en_uturn high.
  - Then uturn_finished=1 for 3 cycles after en_uturn falls; PAUSE2 waits for it to drop; TRACK resumes.
  - Second end_of_track -> lap_count=2, done=1, busy=0.
- Track timeout: start, never assert end_of_track -> fault=1 exactly 40 cycles after en_tracking rose; en_tracking=0; start ignored; abort -> IDLE, fault=0.
- Tie cases:
  - end_of_track arrives on the same cycle the counter hits 39 -> PAUSE1, not FAULT.
  - abort and start together in IDLE -> stays IDLE.
- Stuck uturn_finished: hold it high after UTURN -> stays in PAUSE2, en_tracking=0; fault at counter==39.
- Mid-run abort and reset:
  - abort during UTURN -> next cycle en_uturn=0, lap_count=0.
  - rst low during TRACK -> outputs 0 asynchronously.
  - Restart from DONE with start -> lap_count=0, en_tracking=1.
